mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Multiply/divide unit and its sequencing controller for the P6 five-stage pipeline.
- Owns the HI/LO registers and accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage.
- Models a fixed multi-cycle busy window and drives a stall request so the hazard logic freezes F/D while a dependent MD-class instruction waits in D.
- Instantiated inside datapath, beside the E-stage ALU.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- e_valid  input  1  E-stage holds a real instruction, not a bubble.
- e_md_op  input  4  MD operation code of the E-stage instruction (md_pkg encodings).
- e_rs_data  input  32  forwarded rs operand.
- e_rt_data  input  32  forwarded rt operand.
- d_is_md  input  1  D-stage instruction is any MD-class op.
- md_start  output  1  start pulse, combinational.
- md_busy  output  1  unit is in BUSY state.
- md_stall  output  1  stall request to hazard unit.
- e_md_rdata  output  32  mfhi/mflo read data for E-stage result mux.
- hi_q  output  32  HI register, for debug.
- lo_q  output  32  LO register, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, HI=LO=0, pending result=0. md_busy=0. md_start/md_stall follow inputs combinationally. Reset mid-BUSY aborts the operation; the pending result is discarded.
- start = e_valid & (op in {MULT, MULTU, DIV, DIVU}) & state==IDLE. md_start = start.
- States:
  - IDLE: on start at the edge ending cycle T, latch the computed 64-bit result into pending, load counter=MULT_CYCLES or DIV_CYCLES, go BUSY.
  - BUSY: md_busy=1. Decrement counter each cycle. When counter==1, write HI=pending[63:32], LO=pending[31:0] and go IDLE.
- Net timing: busy is high for cycles T+1..T+N. New HI/LO are visible from cycle T+N+1. An mfhi in E at T+N+1 returns the new value.
- md_stall = d_is_md & (md_start | md_busy), combinational. It covers mf*/mt* and back-to-back mult/div.
- MD op in E while BUSY: the stall guarantees this cannot occur. If it does, the op is ignored and the bench flags an assertion failure.
- mthi/mtlo: take effect only when e_valid and IDLE. Write HI or LO from e_rs_data at the clock edge.
- e_md_rdata: HI for MFHI, LO for MFLO, else 0. Combinational, reflects registered HI/LO, no bypass.
- Arithmetic:
  - mult: signed 32x32→64.
  - multu: unsigned 32x32→64.
  - div/divu: LO=quotient, HI=remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- Divide by zero: still busy for DIV_CYCLES, but HI/LO stay unchanged at completion (pending is marked invalid).
- e_valid=0: no state change, regardless of e_md_op.

Decomposition:
- Package md_pkg holds:
  - op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - state encodings: IDLE=0, BUSY=1.
  - default cycle constants.
- One sub-module, mdu_calc: purely combinational op + operands → 64-bit result plus valid flag (valid=0 on divide by zero).
- mdu_ctrl holds the FSM, counter, pending result, HI/LO and the stall/read logic.

Test Plan:
- mult rs=0xFFFFFFFE, rt=3 at cycle T → busy T+1..T+5, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi at T+6 reads 0xFFFFFFFF.
- divu rs=100, rt=7 → busy exactly 10 cycles, then LO=14, HI=2. div rs=-7, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div with rt=0 after mthi 0x1234, mtlo 0x5678 → busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
- multu in E with d_is_md=1 (mflo) → md_stall high at T (start) and T+1..T+5; low at T+6; mflo reads the new LO.
- Reset asserted at T+3 of a div → md_busy=0 immediately, HI=LO=0, later mfhi returns 0, no late write after release.
- e_valid=0 with e_md_op=MULT → md_start=0, md_busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and default timing constants for the multiply/divide unit.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: returns {HI, LO} and a valid flag
// that drops on divide by zero so the controller leaves HI/LO untouched.
module mdu_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        valid
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        rs_abs, rt_abs;
  logic [31:0]        div_u, div_s;
  logic [31:0]        quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;
  logic               rt_zero;

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed division on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign rs_abs  = rs[31] ? (~rs + 32'd1) : rs;
  assign rt_abs  = rt[31] ? (~rt + 32'd1) : rt;
  assign rt_zero = (rt == 32'd0);
  assign div_u   = rt_zero ? 32'd1 : rt;
  assign div_s   = rt_zero ? 32'd1 : rt_abs;
  assign quo_u   = rs / div_u;
  assign rem_u   = rs % div_u;
  assign quo_m   = rs_abs / div_s;
  assign rem_m   = rs_abs % div_s;
  assign quo_s   = (rs[31] ^ rt[31]) ? (~quo_m + 32'd1) : quo_m;
  assign rem_s   = rs[31] ? (~rem_m + 32'd1) : rem_m;

  always_comb begin
    result = '0;
    valid  = 1'b0;
    case (md_op_e'(op))
      MD_MULT:  begin result = $unsigned(prod_s); valid = 1'b1;     end
      MD_MULTU: begin result = prod_u;            valid = 1'b1;     end
      MD_DIV:   begin result = {rem_s, quo_s};    valid = !rt_zero; end
      MD_DIVU:  begin result = {rem_u, quo_u};    valid = !rt_zero; end
      default:  begin result = '0;                valid = 1'b0;     end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MD unit controller: fixed-latency busy window, HI/LO ownership, stall request
// and mfhi/mflo read path for the E stage.
module mdu_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs_data,
  input  logic [31:0] e_rt_data,
  input  logic        d_is_md,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_stall,
  output logic [31:0] e_md_rdata,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      hi_d, lo_d;
  logic [63:0]      calc_result;
  logic             calc_valid;
  logic             is_mul, is_div, start;

  mdu_calc u_calc (
    .op     (e_md_op),
    .rs     (e_rs_data),
    .rt     (e_rt_data),
    .result (calc_result),
    .valid  (calc_valid)
  );

  assign is_mul   = (e_md_op == MD_MULT) || (e_md_op == MD_MULTU);
  assign is_div   = (e_md_op == MD_DIV)  || (e_md_op == MD_DIVU);
  assign start    = e_valid && (is_mul || is_div) && (state_q == ST_IDLE);
  assign md_start = start;
  assign md_busy  = (state_q == ST_BUSY);
  assign md_stall = d_is_md && (start || md_busy);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_BUSY;
          cnt_d        = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_d       = calc_result;
          pend_valid_d = calc_valid;
        end else if (e_valid && (e_md_op == MD_MTHI)) begin
          hi_d = e_rs_data;
        end else if (e_valid && (e_md_op == MD_MTLO)) begin
          lo_d = e_rs_data;
        end
      end
      ST_BUSY: begin
        // Ops arriving in E here are dropped; the stall keeps them in D.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (pend_valid_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  always_comb begin
    e_md_rdata = '0;
    if (e_md_op == MD_MFHI)      e_md_rdata = hi_q;
    else if (e_md_op == MD_MFLO) e_md_rdata = lo_q;
  end

endmodule
